// File: rtl/arith_pkg.sv
// Shared opcodes, FSM states and FIFO entry layout
// for the add/sub result stage.
package arith_pkg;

  localparam int DATA_W = 4;

  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_BAD = 2'b11;

  typedef enum logic {
    ST_IDLE,
    ST_CHAIN
  } state_e;

  typedef struct packed {
    logic              last;
    logic              z;
    logic              n;
    logic              v;
    logic              c;
    logic [DATA_W-1:0] result;
  } entry_t;

endpackage

// File: rtl/arith_result_fifo.sv
// Small FIFO of result entries; head is read straight
// from the storage flops, so no input->output path.
module arith_result_fifo
  import arith_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push,
  input  entry_t wdata,
  input  logic   pop,
  output entry_t rdata,
  output logic   full,
  output logic   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  entry_t         mem_q [DEPTH];
  entry_t         mem_d [DEPTH];
  logic [AW-1:0]  wp_q, wp_d;
  logic [AW-1:0]  rp_q, rp_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           do_push;
  logic           do_pop;

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign rdata = mem_q[rp_q];

  always_comb begin
    mem_d   = mem_q;
    wp_d    = wp_q;
    rp_d    = rp_q;
    cnt_d   = cnt_q;
    do_push = push && !full;
    do_pop  = pop && !empty;
    if (do_push) begin
      mem_d[wp_q] = wdata;
      wp_d        = wp_q + AW'(1);
    end
    if (do_pop) begin
      rp_d = rp_q + AW'(1);
    end
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/arith_result_stage.sv
// Result select, flag derivation and nibble-chain
// tracking in front of the result FIFO.
module arith_result_stage
  import arith_pkg::*;
#(
  parameter int WIDTH       = DATA_W,
  parameter int DEPTH       = 2,
  parameter int MAX_NIBBLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op_code,
  input  logic [WIDTH-1:0] add_y,
  input  logic [WIDTH-1:0] sub_y,
  input  logic             carry_in,
  input  logic             ovf_in,
  input  logic             in_last,
  output logic             carry_fb,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_c,
  output logic             flag_v,
  output logic             flag_n,
  output logic             flag_z,
  output logic             out_last,
  input  logic             clr_err,
  output logic             err
);

  localparam int CW = $clog2(MAX_NIBBLES + 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    nib_q, nib_d;
  logic             zacc_q, zacc_d;
  logic             cfb_q, cfb_d;
  logic             err_q, err_d;

  logic             accept;
  logic             is_arith;
  logic             is_bad;
  logic [WIDTH-1:0] res;
  logic             res_zero;
  logic             zacc_nx;
  logic             close;
  logic             trunc;
  logic             push;
  entry_t           ent;
  entry_t           head;
  logic             full;
  logic             empty;

  assign in_ready = !full;
  assign accept   = in_valid && in_ready;

  always_comb begin
    is_arith = 1'b0;
    is_bad   = 1'b0;
    res      = '0;
    unique case (1'b1)
      (op_code == OP_ADD): begin
        is_arith = 1'b1;
        res      = add_y;
      end
      (op_code == OP_SUB): begin
        is_arith = 1'b1;
        res      = sub_y;
      end
      (op_code == OP_BAD): is_bad = 1'b1;
      default: ;
    endcase
  end

  assign res_zero = (res == '0);
  assign zacc_nx  = zacc_q && res_zero;

  always_comb begin
    state_d    = state_q;
    nib_d      = nib_q;
    zacc_d     = zacc_q;
    cfb_d      = cfb_q;
    push       = 1'b0;
    close      = 1'b0;
    trunc      = 1'b0;
    ent.result = res;
    ent.c      = carry_in;
    ent.v      = ovf_in;
    ent.n      = res[WIDTH-1];
    ent.z      = res_zero;
    ent.last   = in_last;
    if (accept && is_arith) begin
      push = 1'b1;
      unique case (state_q)
        ST_IDLE: begin
          if (in_last) begin
            cfb_d = 1'b0;
          end else begin
            cfb_d   = carry_in;
            nib_d   = CW'(1);
            zacc_d  = res_zero;
            state_d = ST_CHAIN;
          end
        end
        ST_CHAIN: begin
          cfb_d  = carry_in;
          zacc_d = zacc_nx;
          nib_d  = nib_q + CW'(1);
          close  = in_last ||
                   (nib_q == CW'(MAX_NIBBLES - 1));
          if (close) begin
            // z of a closing entry covers the whole op
            ent.last = 1'b1;
            ent.z    = zacc_nx;
            cfb_d    = 1'b0;
            nib_d    = '0;
            state_d  = ST_IDLE;
            trunc    = !in_last;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    err_d = err_q;
    if (accept && (is_bad || trunc)) begin
      err_d = 1'b1;
    end else if (clr_err) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      nib_q   <= '0;
      zacc_q  <= 1'b0;
      cfb_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      nib_q   <= nib_d;
      zacc_q  <= zacc_d;
      cfb_q   <= cfb_d;
      err_q   <= err_d;
    end
  end

  arith_result_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (ent),
    .pop   (out_ready),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  assign out_valid = !empty;
  assign result    = head.result;
  assign flag_c    = head.c;
  assign flag_v    = head.v;
  assign flag_n    = head.n;
  assign flag_z    = head.z;
  assign out_last  = head.last;
  assign carry_fb  = cfb_q;
  assign err       = err_q;

endmodule

// File: tb/tb_arith_result_stage.sv
// Randomized and directed bench for arith_result_stage
// against a queue-based model of operations and FIFO.
module tb_arith_result_stage;

  localparam int DEPTH = 2;
  localparam int MAXN  = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [1:0] op_code = 2'b00;
  logic [3:0] add_y = '0;
  logic [3:0] sub_y = '0;
  logic       carry_in = 1'b0;
  logic       ovf_in = 1'b0;
  logic       in_last = 1'b0;
  logic       carry_fb;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] result;
  logic       flag_c, flag_v, flag_n, flag_z;
  logic       out_last;
  logic       clr_err = 1'b0;
  logic       err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [8:0] mq[$];
  logic [3:0] nibs[$];
  logic       m_cf;
  logic       m_err;

  arith_result_stage #(
    .WIDTH       (4),
    .DEPTH       (DEPTH),
    .MAX_NIBBLES (MAXN)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_code   (op_code),
    .add_y     (add_y),
    .sub_y     (sub_y),
    .carry_in  (carry_in),
    .ovf_in    (ovf_in),
    .in_last   (in_last),
    .carry_fb  (carry_fb),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flag_c    (flag_c),
    .flag_v    (flag_v),
    .flag_n    (flag_n),
    .flag_z    (flag_z),
    .out_last  (out_last),
    .clr_err   (clr_err),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got %0h expected %0h",
               tag, obs, exp);
    end
  endtask

  function automatic bit all_zero();
    foreach (nibs[i]) if (nibs[i] != 0) return 0;
    return 1;
  endfunction

  task automatic model_step();
    bit         acc, cl, es;
    logic [3:0] r;
    acc = in_valid && (mq.size() < DEPTH);
    es  = 0;
    if (out_ready && mq.size() != 0)
      void'(mq.pop_front());
    if (acc && op_code == 2'b11) es = 1;
    if (acc && (op_code == 2'b01 || op_code == 2'b10)) begin
      r = (op_code == 2'b01) ? add_y : sub_y;
      nibs.push_back(r);
      cl = in_last || (nibs.size() == MAXN);
      if (cl && !in_last) es = 1;
      mq.push_back({cl, cl ? all_zero() : (r == 0),
                    r[3], ovf_in, carry_in, r});
      m_cf = cl ? 1'b0 : carry_in;
      if (cl) nibs.delete();
    end
    if (es) m_err = 1;
    else if (clr_err) m_err = 0;
  endtask

  task automatic check_all();
    chk("in_ready", in_ready, mq.size() < DEPTH);
    chk("out_valid", out_valid, mq.size() != 0);
    if (mq.size() != 0)
      chk("head", {out_last, flag_z, flag_n, flag_v,
                   flag_c, result}, mq[0]);
    chk("carry_fb", carry_fb, m_cf);
    chk("err", err, m_err);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    clr_err  = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_carry_fb", carry_fb, 0);
    chk("rst_err", err, 0);
    chk("rst_head", {out_last, flag_z, flag_n, flag_v,
                     flag_c, result}, 0);
    mq.delete();
    nibs.delete();
    m_cf  = 0;
    m_err = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_in(input logic [1:0] op,
                        input logic [3:0] a,
                        input logic [3:0] s,
                        input logic c,
                        input logic v,
                        input logic l);
    op_code  = op;
    add_y    = a;
    sub_y    = s;
    carry_in = c;
    ovf_in   = v;
    in_last  = l;
  endtask

  task automatic send(input logic [1:0] op,
                      input logic [3:0] a,
                      input logic [3:0] s,
                      input logic c,
                      input logic v,
                      input logic l);
    bit acc;
    bit done = 0;
    set_in(op, a, s, c, v, l);
    in_valid = 1'b1;
    for (int k = 0; k < 20 && !done; k++) begin
      acc = (mq.size() < DEPTH);
      cycle();
      done = acc;
    end
    if (!done) chk("send_timeout", 1, 0);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int k = 0; k < n; k++) cycle();
  endtask

  initial begin
    #1;
    do_reset();

    // 1: single add
    out_ready = 1'b1;
    send(2'b01, 4'hF, 4'h0, 1'b1, 1'b0, 1'b1);
    chk("t1_result", result, 4'hF);
    chk("t1_flags", {out_last, flag_z, flag_n, flag_c},
        4'b1011);
    idle(2);

    // 2: 3-nibble zero sub, held to inspect entries
    out_ready = 1'b0;
    send(2'b10, 4'h3, 4'h0, 1'b0, 1'b0, 1'b0);
    send(2'b10, 4'h3, 4'h0, 1'b0, 1'b0, 1'b0);
    out_ready = 1'b1;
    send(2'b10, 4'h3, 4'h0, 1'b0, 1'b0, 1'b1);
    idle(3);

    // 3: backpressure with DEPTH=2
    out_ready = 1'b0;
    send(2'b01, 4'h1, 4'h0, 1'b0, 1'b0, 1'b1);
    send(2'b01, 4'h2, 4'h0, 1'b1, 1'b0, 1'b1);
    set_in(2'b01, 4'h3, 4'h0, 1'b0, 1'b1, 1'b1);
    in_valid = 1'b1;
    cycle();
    cycle();
    chk("t3_held", in_ready, 0);
    out_ready = 1'b1;
    send(2'b01, 4'h3, 4'h0, 1'b0, 1'b1, 1'b1);
    idle(4);

    // 4: illegal / nop, clear, mid-chain illegal
    send(2'b11, 4'h5, 4'h5, 1'b1, 1'b1, 1'b1);
    send(2'b00, 4'h5, 4'h5, 1'b1, 1'b1, 1'b1);
    chk("t4_err", err, 1);
    clr_err = 1'b1;
    cycle();
    clr_err = 1'b0;
    chk("t4_clr", err, 0);
    send(2'b01, 4'h8, 4'h0, 1'b1, 1'b0, 1'b0);
    send(2'b11, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    chk("t4_cfb_kept", carry_fb, 1);
    send(2'b01, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
    idle(2);
    clr_err = 1'b1;
    cycle();
    clr_err = 1'b0;

    // 5: truncated chain
    for (int i = 0; i < MAXN; i++)
      send(2'b01, 4'(i), 4'h0, 1'b1, 1'b0, 1'b0);
    chk("t5_err", err, 1);
    chk("t5_cfb", carry_fb, 0);
    idle(3);

    // 6: reset mid-chain with a full FIFO
    out_ready = 1'b0;
    send(2'b01, 4'h4, 4'h0, 1'b1, 1'b0, 1'b0);
    send(2'b01, 4'h5, 4'h0, 1'b1, 1'b0, 1'b0);
    chk("t6_full", in_ready, 0);
    do_reset();
    out_ready = 1'b1;
    send(2'b01, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
    idle(2);

    // random
    for (int k = 0; k < 600; k++) begin
      int r;
      in_valid = ($urandom % 4) != 0;
      r = $urandom % 8;
      op_code = (r == 0) ? 2'b00 : (r == 1) ? 2'b11 :
                (r[0] ? 2'b01 : 2'b10);
      add_y = ($urandom % 3 == 0) ? 4'h0 : 4'($urandom);
      sub_y = ($urandom % 3 == 0) ? 4'h0 : 4'($urandom);
      carry_in  = 1'($urandom);
      ovf_in    = 1'($urandom);
      in_last   = ($urandom % 3) == 0;
      out_ready = ($urandom % 4) != 0;
      clr_err   = ($urandom % 16) == 0;
      cycle();
    end
    clr_err = 1'b0;
    out_ready = 1'b1;
    idle(4);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
